// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: shares the single VRAM read port between the background
// fetcher, the sprite fetcher and the CPU. One read is outstanding at a time.
// During drawing (mode 3) sprites preempt the background fetch.
// Optional build macro VRAM_ARB_CPU_BLOCK_EN: when defined, CPU reads in
// mode 3 never reach VRAM and complete as out-of-range reads returning 8'hFF.
module ppu_vram_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter logic [15:0] VRAM_BASE    = 16'h8000,
  parameter logic [15:0] VRAM_TOP     = 16'h9FFF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        tclk_in,
  input  logic [1:0]  mode_in,
  input  logic        sprite_hit_in,
  input  logic        bg_req_in,
  input  logic [15:0] bg_addr_in,
  output logic [7:0]  bg_data_out,
  output logic        bg_data_valid_out,
  input  logic        spr_req_in,
  input  logic [15:0] spr_addr_in,
  output logic [7:0]  spr_data_out,
  output logic        spr_data_valid_out,
  input  logic        cpu_req_in,
  input  logic [15:0] cpu_addr_in,
  output logic [7:0]  cpu_data_out,
  output logic        cpu_data_valid_out,
  output logic [12:0] vram_addr_out,
  output logic        vram_rd_out,
  input  logic [7:0]  vram_data_in,
  output logic [1:0]  grant_out,
  output logic        busy_out
);

  localparam int unsigned AW = 16;
  localparam int unsigned VW = 13;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_BG   = 2'd1;
  localparam logic [1:0] OWN_SPR  = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RETURN} state_t;

  state_t         state_q, state_d;
  logic           oor_q, oor_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     grant_d;
  logic           rd_d;
  logic [VW-1:0]  vaddr_d;
  logic           busy_d;
  logic [DW-1:0]  bg_data_d, spr_data_d, cpu_data_d;
  logic           bg_valid_d, spr_valid_d, cpu_valid_d;

  logic           drawing_c, bg_ok_c, cpu_oor_c, win_oor_c;
  logic [1:0]     win_c;
  logic [AW-1:0]  win_addr_c;
  logic [DW-1:0]  ret_data_c;

  function automatic logic in_vram(input logic [AW-1:0] a);
    return (a >= VRAM_BASE) && (a <= VRAM_TOP);
  endfunction

  // Mode-dependent priority selection among eligible requesters
  always_comb begin
    drawing_c = (mode_in == 2'd3);
    bg_ok_c   = bg_req_in && !(drawing_c && sprite_hit_in);
`ifdef VRAM_ARB_CPU_BLOCK_EN
    cpu_oor_c = drawing_c || !in_vram(cpu_addr_in);
`else
    cpu_oor_c = !in_vram(cpu_addr_in);
`endif
    win_c = OWN_NONE;
    if (drawing_c) begin
      if (spr_req_in)      win_c = OWN_SPR;
      else if (bg_ok_c)    win_c = OWN_BG;
      else if (cpu_req_in) win_c = OWN_CPU;
    end else begin
      if (cpu_req_in)      win_c = OWN_CPU;
      else if (spr_req_in) win_c = OWN_SPR;
      else if (bg_ok_c)    win_c = OWN_BG;
    end
    win_addr_c = bg_addr_in;
    win_oor_c  = !in_vram(bg_addr_in);
    case (win_c)
      OWN_SPR: begin
        win_addr_c = spr_addr_in;
        win_oor_c  = !in_vram(spr_addr_in);
      end
      OWN_CPU: begin
        win_addr_c = cpu_addr_in;
        win_oor_c  = cpu_oor_c;
      end
      default: ;
    endcase
  end

  // Next-state and next-output logic for the read sequencer
  always_comb begin
    state_d     = state_q;
    oor_d       = oor_q;
    cnt_d       = cnt_q;
    grant_d     = grant_out;
    rd_d        = 1'b0;
    vaddr_d     = vram_addr_out;
    bg_data_d   = bg_data_out;
    spr_data_d  = spr_data_out;
    cpu_data_d  = cpu_data_out;
    bg_valid_d  = 1'b0;
    spr_valid_d = 1'b0;
    cpu_valid_d = 1'b0;
    ret_data_c  = oor_q ? 8'hFF : vram_data_in;
    case (state_q)
      ST_IDLE: begin
        if (tclk_in && (win_c != OWN_NONE)) begin
          grant_d = win_c;
          oor_d   = win_oor_c;
          state_d = ST_ISSUE;
          if (!win_oor_c) begin
            rd_d    = 1'b1;
            vaddr_d = VW'(win_addr_c - VRAM_BASE);
          end
        end
      end
      ST_ISSUE: begin
        if (oor_q) begin
          state_d = ST_RETURN;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CW'(READ_LATENCY - 1);
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RETURN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_RETURN: begin
        case (grant_out)
          OWN_BG: begin
            bg_data_d  = ret_data_c;
            bg_valid_d = 1'b1;
          end
          OWN_SPR: begin
            spr_data_d  = ret_data_c;
            spr_valid_d = 1'b1;
          end
          OWN_CPU: begin
            cpu_data_d  = ret_data_c;
            cpu_valid_d = 1'b1;
          end
          default: ;
        endcase
        grant_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset abandons any in-flight read
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q            <= ST_IDLE;
      oor_q              <= 1'b0;
      cnt_q              <= '0;
      grant_out          <= OWN_NONE;
      vram_rd_out        <= 1'b0;
      vram_addr_out      <= '0;
      busy_out           <= 1'b0;
      bg_data_out        <= '0;
      spr_data_out       <= '0;
      cpu_data_out       <= '0;
      bg_data_valid_out  <= 1'b0;
      spr_data_valid_out <= 1'b0;
      cpu_data_valid_out <= 1'b0;
    end else begin
      state_q            <= state_d;
      oor_q              <= oor_d;
      cnt_q              <= cnt_d;
      grant_out          <= grant_d;
      vram_rd_out        <= rd_d;
      vram_addr_out      <= vaddr_d;
      busy_out           <= busy_d;
      bg_data_out        <= bg_data_d;
      spr_data_out       <= spr_data_d;
      cpu_data_out       <= cpu_data_d;
      bg_data_valid_out  <= bg_valid_d;
      spr_data_valid_out <= spr_valid_d;
      cpu_data_valid_out <= cpu_valid_d;
    end
  end

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Self-checking bench for ppu_vram_arbiter. Honours VRAM_ARB_CPU_BLOCK_EN
// so the same bench covers both builds.
module tb_ppu_vram_arbiter;

  localparam int unsigned RL = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        tclk_in = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic        sprite_hit_in = 1'b0;
  logic        bg_req_in = 1'b0;
  logic [15:0] bg_addr_in = 16'h0;
  logic [7:0]  bg_data_out;
  logic        bg_data_valid_out;
  logic        spr_req_in = 1'b0;
  logic [15:0] spr_addr_in = 16'h0;
  logic [7:0]  spr_data_out;
  logic        spr_data_valid_out;
  logic        cpu_req_in = 1'b0;
  logic [15:0] cpu_addr_in = 16'h0;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_valid_out;
  logic [12:0] vram_addr_out;
  logic        vram_rd_out;
  logic [7:0]  vram_data_in = 8'h00;
  logic [1:0]  grant_out;
  logic        busy_out;

  ppu_vram_arbiter #(.READ_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in), .mode_in(mode_in),
    .sprite_hit_in(sprite_hit_in),
    .bg_req_in(bg_req_in), .bg_addr_in(bg_addr_in),
    .bg_data_out(bg_data_out), .bg_data_valid_out(bg_data_valid_out),
    .spr_req_in(spr_req_in), .spr_addr_in(spr_addr_in),
    .spr_data_out(spr_data_out), .spr_data_valid_out(spr_data_valid_out),
    .cpu_req_in(cpu_req_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_out(cpu_data_out), .cpu_data_valid_out(cpu_data_valid_out),
    .vram_addr_out(vram_addr_out), .vram_rd_out(vram_rd_out),
    .vram_data_in(vram_data_in), .grant_out(grant_out), .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // VRAM contents as seen at a 13-bit word address
  function automatic logic [7:0] mem_fn(input logic [12:0] a);
    if (a == 13'h1800) return 8'h3C;
    return (a[7:0] ^ 8'hA5) ^ {3'b000, a[12:8]};
  endfunction

  // T-cycle strobe: one clk every four, gated by tclk_en
  logic tclk_en = 1'b1;
  int   tcnt = 0;
  always @(negedge clk_in) begin
    tcnt    <= (tcnt + 1) % 4;
    tclk_in <= tclk_en && (tcnt == 3);
  end

  // VRAM model: data appears RL clocks after the sampled read strobe and holds
  int          vr_cnt = 0;
  logic [12:0] vr_addr = 13'h0;
  always @(posedge clk_in) begin
    if (vr_cnt > 0) begin
      vr_cnt--;
      if (vr_cnt == 0) vram_data_in <= mem_fn(vr_addr);
    end
    if (vram_rd_out) begin
      vr_addr = vram_addr_out;
      vr_cnt  = int'(RL);
      vram_data_in <= 8'h00;
    end
  end

  // Transaction-level model: a grant schedules the response a fixed number of clocks later
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_own = 0;
  int          m_done = 0;
  logic [7:0]  m_data = 8'h0;
  int          m_order [3];
  int          m_win;
  bit          m_draw;
  bit          m_oor;
  logic [15:0] m_addr;
  logic [1:0]  exp_grant = 2'd0;
  bit          exp_busy = 1'b0;
  bit          exp_rd = 1'b0;
  logic [12:0] exp_vaddr = 13'h0;
  bit          exp_valid [1:3];
  logic [7:0]  exp_data [1:3];

  function automatic bit elig(input int who, input bit drawing);
    case (who)
      1:       return bg_req_in && !(drawing && sprite_hit_in);
      2:       return spr_req_in;
      default: return cpu_req_in;
    endcase
  endfunction

  function automatic logic [15:0] req_addr(input int who);
    case (who)
      1:       return bg_addr_in;
      2:       return spr_addr_in;
      default: return cpu_addr_in;
    endcase
  endfunction

  always @(posedge clk_in) begin
    cyc++;
    if (rst_in) begin
      m_active  = 1'b0;
      exp_grant = 2'd0;
      exp_busy  = 1'b0;
      exp_rd    = 1'b0;
      exp_vaddr = 13'h0;
      for (int i = 1; i <= 3; i++) begin
        exp_valid[i] = 1'b0;
        exp_data[i]  = 8'h00;
      end
    end else begin
      exp_rd = 1'b0;
      for (int i = 1; i <= 3; i++) exp_valid[i] = 1'b0;
      if (m_active) begin
        if (cyc == m_done) begin
          exp_valid[m_own] = 1'b1;
          exp_data[m_own]  = m_data;
          exp_grant = 2'd0;
          exp_busy  = 1'b0;
          m_active  = 1'b0;
        end
      end else if (tclk_in) begin
        m_draw = (mode_in == 2'd3);
        if (m_draw) m_order = '{2, 1, 3};
        else        m_order = '{3, 2, 1};
        m_win = 0;
        for (int i = 0; i < 3; i++)
          if (m_win == 0 && elig(m_order[i], m_draw)) m_win = m_order[i];
        if (m_win != 0) begin
          m_addr = req_addr(m_win);
          m_oor  = (m_addr < 16'h8000) || (m_addr > 16'h9FFF);
`ifdef VRAM_ARB_CPU_BLOCK_EN
          if (m_win == 3 && m_draw) m_oor = 1'b1;
`endif
          m_active  = 1'b1;
          m_own     = m_win;
          m_done    = cyc + (m_oor ? 2 : int'(RL) + 2);
          m_data    = m_oor ? 8'hFF : mem_fn(13'(m_addr - 16'h8000));
          exp_grant = 2'(m_win);
          exp_busy  = 1'b1;
          exp_rd    = !m_oor;
          if (!m_oor) exp_vaddr = 13'(m_addr - 16'h8000);
        end
      end
    end
  end

  // Per-cycle compare against the model, plus event logging for directed checks
  int         nval [1:3];
  int         vcyc [1:3];
  int         nrd = 0;
  int         gcyc = 0;
  int         glog [$];
  logic [1:0] prev_grant = 2'd0;

  initial for (int i = 1; i <= 3; i++) begin nval[i] = 0; vcyc[i] = 0; end

  always @(posedge clk_in) begin
    #1;
    if (!rst_in) begin
      chk("grant_out", 16'(grant_out), 16'(exp_grant));
      chk("busy_out", 16'(busy_out), 16'(exp_busy));
      chk("vram_rd_out", 16'(vram_rd_out), 16'(exp_rd));
      chk("vram_addr_out", 16'(vram_addr_out), 16'(exp_vaddr));
      chk("bg_valid", 16'(bg_data_valid_out), 16'(exp_valid[1]));
      chk("spr_valid", 16'(spr_data_valid_out), 16'(exp_valid[2]));
      chk("cpu_valid", 16'(cpu_data_valid_out), 16'(exp_valid[3]));
      chk("bg_data", 16'(bg_data_out), 16'(exp_data[1]));
      chk("spr_data", 16'(spr_data_out), 16'(exp_data[2]));
      chk("cpu_data", 16'(cpu_data_out), 16'(exp_data[3]));
    end
    if (vram_rd_out) nrd++;
    if (bg_data_valid_out)  begin nval[1]++; vcyc[1] = cyc; end
    if (spr_data_valid_out) begin nval[2]++; vcyc[2] = cyc; end
    if (cpu_data_valid_out) begin nval[3]++; vcyc[3] = cyc; end
    if (grant_out != 2'd0 && prev_grant == 2'd0) begin
      glog.push_back(int'(grant_out));
      gcyc = cyc;
    end
    prev_grant = grant_out;
  end

  task automatic wait_grant(input int budget);
    int n = 0;
    while (grant_out == 2'd0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    chk("grant_seen", 16'(grant_out != 2'd0), 16'd1);
  endtask

  task automatic drop_on_strobe();
    if (bg_data_valid_out)  bg_req_in  = 1'b0;
    if (spr_data_valid_out) spr_req_in = 1'b0;
    if (cpu_data_valid_out) cpu_req_in = 1'b0;
  endtask

  task automatic wait_strobe(input int who, input int budget);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk_in);
      n++;
      seen = (who == 1) ? bg_data_valid_out : (who == 2) ? spr_data_valid_out : cpu_data_valid_out;
      drop_on_strobe();
    end
    chk("strobe_seen", 16'(seen), 16'd1);
  endtask

  task automatic finish_all(input int budget);
    int n = 0;
    bit pend = 1'b1;
    while (pend && n < budget) begin
      @(negedge clk_in);
      n++;
      drop_on_strobe();
      pend = bg_req_in || spr_req_in || cpu_req_in || busy_out;
    end
    chk("drain", 16'(pend), 16'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 16'(grant_out), 16'd0);
    chk({tag, "_busy"}, 16'(busy_out), 16'd0);
    chk({tag, "_rd"}, 16'(vram_rd_out), 16'd0);
    chk({tag, "_vaddr"}, 16'(vram_addr_out), 16'd0);
    chk({tag, "_valids"}, 16'({bg_data_valid_out, spr_data_valid_out, cpu_data_valid_out}), 16'd0);
    chk({tag, "_datas"}, 16'(bg_data_out | spr_data_out | cpu_data_out), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end at %0t", $time);
    $fatal(1, "watchdog");
  end

  int r0, b0, s0, c0;

  initial begin
    repeat (3) @(negedge clk_in);
    chk_all_zero("reset");
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Reset during WAIT abandons the read
    mode_in = 2'd0; bg_addr_in = 16'h8010; bg_req_in = 1'b1;
    wait_grant(16);
    chk("rst_grant_bg", 16'(grant_out), 16'd1);
    @(negedge clk_in);
    chk("rst_busy_wait", 16'(busy_out), 16'd1);
    b0 = nval[1];
    rst_in = 1'b1; bg_req_in = 1'b0;
    #1;
    chk_all_zero("midwait_reset");
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    chk("rst_no_bg_strobe", 16'(nval[1] - b0), 16'd0);

    // Basic in-range CPU read
    r0 = nrd;
    cpu_addr_in = 16'h9800; cpu_req_in = 1'b1;
    finish_all(40);
    chk("basic_latency", 16'(vcyc[3] - gcyc), 16'd4);
    chk("basic_data", 16'(cpu_data_out), 16'h003C);
    chk("basic_rd_pulses", 16'(nrd - r0), 16'd1);
    chk("basic_vaddr", 16'(vram_addr_out), 16'h1800);

    // No grant without a T-cycle strobe
    tclk_en = 1'b0;
    cpu_addr_in = 16'h8005; cpu_req_in = 1'b1;
    repeat (12) @(negedge clk_in);
    chk("notclk_grant", 16'(grant_out), 16'd0);
    chk("notclk_busy", 16'(busy_out), 16'd0);
    tclk_en = 1'b1;
    finish_all(40);
    chk("notclk_data", 16'(cpu_data_out), 16'h00A0);

    // Out-of-range CPU read
    r0 = nrd;
    cpu_addr_in = 16'hC000; cpu_req_in = 1'b1;
    finish_all(40);
    chk("oor_latency", 16'(vcyc[3] - gcyc), 16'd2);
    chk("oor_data", 16'(cpu_data_out), 16'h00FF);
    chk("oor_rd_pulses", 16'(nrd - r0), 16'd0);

    // Sprite preemption of the background fetch during drawing
    mode_in = 2'd3; sprite_hit_in = 1'b1;
    bg_addr_in = 16'h8010; spr_addr_in = 16'h8020;
    bg_req_in = 1'b1; spr_req_in = 1'b1;
    wait_grant(16);
    chk("preempt_first_spr", 16'(grant_out), 16'd2);
    wait_strobe(2, 40);
    chk("preempt_spr_data", 16'(spr_data_out), 16'h0085);
    repeat (8) @(negedge clk_in);
    chk("preempt_bg_held", 16'(grant_out), 16'd0);
    sprite_hit_in = 1'b0;
    finish_all(40);
    chk("preempt_bg_last", 16'(glog[glog.size() - 1]), 16'd1);
    chk("preempt_bg_data", 16'(bg_data_out), 16'h00B5);

    // CPU read while drawing
    r0 = nrd;
    cpu_addr_in = 16'h8000; cpu_req_in = 1'b1;
    finish_all(40);
`ifdef VRAM_ARB_CPU_BLOCK_EN
    chk("draw_cpu_rd_pulses", 16'(nrd - r0), 16'd0);
    chk("draw_cpu_data", 16'(cpu_data_out), 16'h00FF);
    chk("draw_cpu_latency", 16'(vcyc[3] - gcyc), 16'd2);
`else
    chk("draw_cpu_rd_pulses", 16'(nrd - r0), 16'd1);
    chk("draw_cpu_data", 16'(cpu_data_out), 16'h00A5);
    chk("draw_cpu_latency", 16'(vcyc[3] - gcyc), 16'd4);
`endif

    // Three simultaneous requests in VBlank
    mode_in = 2'd1;
    glog.delete();
    b0 = nval[1]; s0 = nval[2]; c0 = nval[3];
    cpu_addr_in = 16'h8001; spr_addr_in = 16'h9F00; bg_addr_in = 16'h8002;
    cpu_req_in = 1'b1; spr_req_in = 1'b1; bg_req_in = 1'b1;
    finish_all(100);
    chk("sim_grant_count", 16'(glog.size()), 16'd3);
    chk("sim_order0", 16'(glog[0]), 16'd3);
    chk("sim_order1", 16'(glog[1]), 16'd2);
    chk("sim_order2", 16'(glog[2]), 16'd1);
    chk("sim_cpu_strobes", 16'(nval[3] - c0), 16'd1);
    chk("sim_spr_strobes", 16'(nval[2] - s0), 16'd1);
    chk("sim_bg_strobes", 16'(nval[1] - b0), 16'd1);
    chk("sim_cpu_data", 16'(cpu_data_out), 16'h00A4);
    chk("sim_spr_data", 16'(spr_data_out), 16'h00BA);
    chk("sim_bg_data", 16'(bg_data_out), 16'h00A7);

    repeat (4) @(negedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppu_vram_arbiter.md
Name: ppu_vram_arbiter

Overview:
- Single-port VRAM read arbiter for the PPU.
- Shares one VRAM read port between three requesters:
  - the background/window fetcher (BackgroundFIFO path),
  - the sprite fetcher,
  - the CPU bus.
- Sequences one outstanding read at a time, applies mode-dependent priority (sprite preemption of the background fetch during drawing), and routes returned data back to the winning requester.

Parameters:
- READ_LATENCY, 2, clk_in cycles from vram_rd_out pulse to valid vram_data_in (1..7).
- VRAM_BASE, 16'h8000, first CPU-space address mapped to VRAM.
- VRAM_TOP, 16'h9FFF, last CPU-space address mapped to VRAM.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- tclk_in  in  1  T-cycle strobe, one clk_in wide
- mode_in  in  2  PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 drawing)
- sprite_hit_in  in  1  sprite fetch pending; suppresses background grants
- bg_req_in  in  1  background fetcher read request (level)
- bg_addr_in  in  16  background fetcher address
- bg_data_out  out  8  read data to background fetcher
- bg_data_valid_out  out  1  one-clk response strobe
- spr_req_in / spr_addr_in / spr_data_out / spr_data_valid_out  same widths, sprite fetcher
- cpu_req_in / cpu_addr_in / cpu_data_out / cpu_data_valid_out  same widths, CPU
- vram_addr_out  out  13  VRAM word address (addr - VRAM_BASE)
- vram_rd_out  out  1  one-clk read strobe
- vram_data_in  in  8  VRAM read data
- grant_out  out  2  current owner: 0 none, 1 bg, 2 spr, 3 cpu
- busy_out  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (async, rst_in=1):
  - FSM returns to IDLE.
  - All outputs are 0: data_out registers, valid strobes, vram_rd_out, vram_addr_out, grant_out, busy_out.
  - An in-flight read is abandoned and no strobe is issued.
- FSM states: IDLE, ISSUE, WAIT, RETURN.
- IDLE:
  - Arbitrates only on a clk with tclk_in=1 and at least one eligible request.
  - On a grant, latches winner and address, sets grant_out, and moves to ISSUE.
  - No grant when tclk_in=0.
- Priority, mode_in==3:
  - spr > bg.
  - bg is ineligible while sprite_hit_in=1.
  - CPU handling per the Optional Feature.
- Priority, mode_in!=3: cpu > spr > bg.
- Out-of-range address (outside VRAM_BASE..VRAM_TOP):
  - ISSUE does not assert vram_rd_out.
  - FSM goes directly to RETURN with data 8'hFF.
- ISSUE: vram_rd_out=1 for exactly one clk, with vram_addr_out = latched address minus VRAM_BASE (13 bits), then WAIT.
- WAIT:
  - Counter is loaded with READ_LATENCY-1 on entry and decremented each clk.
  - At 0, FSM moves to RETURN.
  - With READ_LATENCY=1, WAIT lasts one clk.
- RETURN:
  - Captures vram_data_in (or 8'hFF) into the winner's data_out register.
  - Pulses the winner's valid strobe for one clk.
  - Clears grant_out and returns to IDLE.
- Latency: grant-clk to valid strobe = READ_LATENCY+2 clk for in-range addresses; 2 clk for out-of-range addresses.
- Data retention: each data_out holds its value until that requester's next response.
- Request protocol: requesters hold req and addr until their valid strobe.
  - If req drops mid-transaction, the transaction completes and the strobe still fires.
  - Requests and addresses are not resampled after the grant.
- Mid-transaction changes:
  - A mode_in or sprite_hit_in change mid-transaction does not abort it.
  - It affects only the next arbitration.
- Back-to-back grants: a new grant needs the next tclk_in in IDLE, so there is at most one grant per T-cycle.
- Simultaneous requests: exactly one grant, the highest eligible. Losers stay pending with no strobe.

Optional Feature:
- Macro: VRAM_ARB_CPU_BLOCK_EN.
- Defined:
  - In mode_in==3, a CPU request is never sent to VRAM.
  - It is granted as an out-of-range access and returns 8'hFF after 2 clk.
  - It competes at lowest priority: cpu < bg < spr.
- Undefined:
  - In mode_in==3, the CPU is eligible at lowest priority (spr > bg > cpu).
  - It receives real VRAM data.

Test Plan:
- Reset mid-WAIT: bg read at 16'h8010 with rst_in asserted during WAIT -> all outputs 0 immediately, no bg_data_valid_out, FSM IDLE.
- Basic read, READ_LATENCY=2: mode 0, cpu reads 16'h9800, VRAM returns 8'h3C -> vram_rd_out one clk with vram_addr_out=13'h1800; cpu_data_valid_out 4 clk after grant; cpu_data_out=8'h3C.
- Sprite preemption: mode 3, bg_req and spr_req on the same tclk with sprite_hit_in=1 -> grant_out=2 first; bg granted on a later tclk after the spr strobe and sprite_hit_in=0.
- Out-of-range: mode 0, cpu reads 16'hC000 -> no vram_rd_out; cpu_data_out=8'hFF with valid 2 clk after grant.
- CPU blocked, macro defined: mode 3, cpu reads 16'h8000 -> vram_rd_out stays 0; cpu_data_out=8'hFF. Macro undefined: real data returned.
- Simultaneous requests: mode 1, all three request on one tclk -> serviced in order cpu, spr, bg on successive tclk grants; exactly one strobe each; busy_out high during each transaction.
